// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop serialiser.
// The idle line is high, and back-to-back frames are sent with no idle gap between them.
module uart_tx_fifo #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DEPTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_valid_i,
    input  logic [7:0]               wr_data_i,
    output logic                     wr_ready_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     busy_o,
    output logic                     tx_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int AW           = $clog2(DEPTH);
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop, bit_done;
    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty        = (wr_ptr == rd_ptr);
    assign push         = wr_valid_i && !full;
    assign bit_done     = (baud_cnt == CNT_LAST);
    assign pop          = !empty && ((state == IDLE) || (state == STOP && bit_done));
    assign wr_ready_o   = !full;
    assign fifo_count_o = wr_ptr - rd_ptr;

    // NOTE: storage has no reset; emptiness comes from the pointers alone, so clearing it is wasted logic.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end

    // NOTE: every register here uses non-blocking assignment so all next-state terms see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                shift  <= mem[rd_ptr[AW-1:0]];
            end

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state  <= START;
                        tx_o   <= 1'b0;
                        busy_o <= 1'b1;
                    end else begin
                        tx_o   <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_o     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx_o    <= shift[1];  // next bit, before the shift lands
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state <= START;
                            tx_o  <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic, compared every cycle
// against a queue-and-timeline model of the serial line.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, busy, tx;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(250_000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_valid_i  (wr_valid),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .fifo_count_o(fifo_count),
        .busy_o      (busy),
        .tx_o        (tx)
    );

    int checks   = 0;
    int failures = 0;

    // Model: bytes waiting, plus the frame on the line and how far into it we are.
    byte unsigned q[$];
    bit           in_frame = 1'b0;
    byte unsigned cur = 8'h00;
    int           t = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!in_frame) return 1'b1;
        b = t / C;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur[b-1];
    endfunction

    // Advance the model by one clock edge using the current inputs, then compare all outputs.
    task automatic step();
        bit acc;
        if (rst) begin
            q.delete();
            in_frame = 1'b0;
            t = 0;
        end else begin
            acc = wr_valid && (q.size() < DEPTH);
            if (in_frame && t < FRAME - 1) begin
                t++;
            end else if (q.size() > 0) begin
                cur = q.pop_front();
                in_frame = 1'b1;
                t = 0;
            end else begin
                in_frame = 1'b0;
            end
            if (acc) q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
        check("tx", tx, exp_tx());
        check("busy", busy, in_frame);
        check("count", fifo_count, q.size());
        check("ready", wr_ready, q.size() != DEPTH);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        int density;

        // Reset, then a quiet line.
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(50);
        check("idle_tx", tx, 1);
        check("idle_ready", wr_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_count", fifo_count, 0);

        // Single frame.
        write_byte(8'hA5);
        check("a5_count_after_write", fifo_count, 1);
        step();
        check("a5_start_bit", tx, 0);
        check("a5_popped", fifo_count, 0);
        idle(45);

        // Two frames back to back.
        write_byte(8'h55);
        write_byte(8'h0F);
        idle(90);

        // Overfill: first pops, four queue, sixth is dropped.
        for (int i = 0; i < 6; i++) write_byte(8'h30 + 8'(i));
        check("overfill_ready", wr_ready, 0);
        check("overfill_count", fifo_count, 4);
        idle(5 * FRAME + 10);

        // Hold a write on a full FIFO across a pop cycle.
        for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i));
        wr_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            wr_data = 8'($urandom);
            step();
        end
        wr_valid = 1'b0;
        idle(6 * FRAME);

        // Reset during the data bits of 0xFF with two bytes queued.
        write_byte(8'hFF);
        write_byte(8'h12);
        write_byte(8'h34);
        check("pre_rst_count", fifo_count, 2);
        idle(12);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        idle(3 * FRAME);

        // Random traffic with varying load and rare resets.
        density = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) density = ($urandom_range(0, 2) == 0) ? 5 : (($urandom_range(0, 1) == 0) ? 30 : 90);
            wr_valid = ($urandom_range(0, 99) < density);
            wr_data  = 8'($urandom);
            rst      = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        wr_valid = 1'b0;
        idle(5 * FRAME);
        check("drain_busy", busy, 0);
        check("drain_tx", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
